split_timestamp: RTL and testbench

Downstream neighbour of the timestamp-attach stage. Consumes an AXI4-Stream carrying [Ethernet Frame]/[Timestamp], where the timestamp is appended as the final TIMESTAMP_WIDTH/DATA_WIDTH beats, LSB beat first. Emits the bare frame on one AXI4-Stream, with tlast on the true last frame beat. Emits the recovered timestamp as a single beat on a separate AXI4-Stream. Uses an (N+1)-beat delay buffer, because the frame/timestamp boundary is only known once tlast arrives.

---
 rtl/split_timestamp_if.sv | 13 +
 rtl/split_timestamp.sv | 118 +++++++++++
 tb/tb_split_timestamp.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/split_timestamp_if.sv
// AXI4-Stream style channel shared by the frame input, frame output and timestamp output.
// The timestamp channel carries tlast but always drives it high (single-beat packets).
interface split_timestamp_if #(
    parameter int unsigned Width = 8
);
    logic [Width-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/split_timestamp.sv
// Splits a [frame][timestamp] stream into a bare frame stream and a one-beat timestamp stream.
// An (N+1)-deep shift buffer holds back the tail so the frame/timestamp boundary is known at tlast.
module split_timestamp #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned TIMESTAMP_WIDTH = 72
) (
    input  logic              clk,
    input  logic              rstn,
    split_timestamp_if.slave  s_axis,
    split_timestamp_if.master m_axis,
    split_timestamp_if.master m_axis_timestamp,
    output logic              err_runt
);
    localparam int unsigned N    = TIMESTAMP_WIDTH / DATA_WIDTH;
    localparam int unsigned CntW = $clog2(N + 2);
    localparam logic [CntW-1:0] LastIdx = CntW'(N);

    typedef enum logic [1:0] {StFill, StStream, StFlushLast, StTsOut} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  err_runt_q;
    logic                  fill_en, shift_en, runt;
    logic [DATA_WIDTH-1:0] data_q [N+1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StFill;
            count_q    <= '0;
            err_runt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            err_runt_q <= runt;
        end
    end

    // Buffer contents need no reset; they are only read once filled.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N; i++) begin
            if (shift_en) begin
                data_q[i] <= data_q[i+1];
            end else if (fill_en && count_q == CntW'(i)) begin
                data_q[i] <= s_axis.tdata;
            end
        end
        if (shift_en || (fill_en && count_q == LastIdx)) begin
            data_q[N] <= s_axis.tdata;
        end
    end

    always_comb begin
        state_d                 = state_q;
        count_d                 = count_q;
        fill_en                 = 1'b0;
        shift_en                = 1'b0;
        runt                    = 1'b0;
        s_axis.tready           = 1'b0;
        m_axis.tvalid           = 1'b0;
        m_axis.tlast            = 1'b0;
        m_axis_timestamp.tvalid = 1'b0;
        unique case (state_q)
            StFill: begin
                s_axis.tready = 1'b1;
                if (s_axis.tvalid) begin
                    fill_en = 1'b1;
                    if (count_q == LastIdx) begin
                        count_d = count_q + 1'b1;
                        state_d = s_axis.tlast ? StFlushLast : StStream;
                    end else if (s_axis.tlast) begin
                        // Packet too short to hold even one frame beat: drop it.
                        runt    = 1'b1;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            StStream: begin
                m_axis.tvalid = s_axis.tvalid;
                s_axis.tready = m_axis.tready;
                if (s_axis.tvalid && m_axis.tready) begin
                    shift_en = 1'b1;
                    if (s_axis.tlast) begin
                        state_d = StFlushLast;
                    end
                end
            end
            StFlushLast: begin
                m_axis.tvalid = 1'b1;
                m_axis.tlast  = 1'b1;
                if (m_axis.tready) begin
                    state_d = StTsOut;
                end
            end
            StTsOut: begin
                m_axis_timestamp.tvalid = 1'b1;
                if (m_axis_timestamp.tready) begin
                    state_d = StFill;
                    count_d = '0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Oldest timestamp beat lands in the least significant bits.
    always_comb begin
        m_axis_timestamp.tdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            m_axis_timestamp.tdata[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i+1];
        end
    end

    assign m_axis.tdata          = data_q[0];
    assign m_axis_timestamp.tlast = 1'b1;
    assign err_runt              = err_runt_q;
endmodule

// File: tb/tb_split_timestamp.sv
// Bench for split_timestamp: packet-level model (frame = all but last N beats, timestamp =
// last N beats LSB-first, runt if length <= N) checked against the outputs every cycle.
module tb_split_timestamp;
    localparam int unsigned DW  = 8;
    localparam int unsigned TSW = 72;
    localparam int unsigned N   = TSW / DW;

    typedef logic [DW-1:0] byte_q_t[$];

    logic clk = 1'b0;
    logic rstn;
    logic err_runt;
    always #5 clk = ~clk;

    split_timestamp_if #(.Width(DW))  s_axis ();
    split_timestamp_if #(.Width(DW))  m_axis ();
    split_timestamp_if #(.Width(TSW)) ts_axis ();

    split_timestamp #(
        .DATA_WIDTH     (DW),
        .TIMESTAMP_WIDTH(TSW)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .s_axis          (s_axis),
        .m_axis          (m_axis),
        .m_axis_timestamp(ts_axis),
        .err_runt        (err_runt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [TSW-1:0] got, input logic [TSW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Scoreboard model
    logic [DW:0]    exp_frame[$];
    logic [TSW-1:0] exp_ts[$];
    int             runt_pending = 0;

    task automatic model_push(input byte_q_t p);
        int unsigned    len;
        logic [TSW-1:0] ts;
        len = p.size();
        if (len <= N) begin
            runt_pending++;
        end else begin
            for (int unsigned i = 0; i < len - N; i++)
                exp_frame.push_back({(i == len - N - 1), p[i]});
            ts = '0;
            for (int unsigned j = 0; j < N; j++) ts[j*DW +: DW] = p[len-N+j];
            exp_ts.push_back(ts);
        end
    endtask

    // Observation trackers used by the literal checks
    logic [DW-1:0]  last_data;
    logic           last_tlast;
    logic [TSW-1:0] last_ts;
    int             frame_beats = 0;
    int             ts_beats    = 0;
    int             runt_seen   = 0;

    // Compare process: outputs are sampled mid-cycle, where a valid&ready pair means a transfer
    // at the next rising edge.
    initial begin
        logic           m_stall, t_stall;
        logic [DW:0]    m_prev, e;
        logic [TSW-1:0] t_prev;
        m_stall = 1'b0;
        t_stall = 1'b0;
        m_prev  = '0;
        t_prev  = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                exp_frame.delete();
                exp_ts.delete();
                runt_pending = 0;
                m_stall      = 1'b0;
                t_stall      = 1'b0;
            end else begin
                if (m_stall) begin
                    check("m_hold_valid", m_axis.tvalid, 1);
                    check("m_hold_data", {m_axis.tlast, m_axis.tdata}, m_prev);
                end
                if (t_stall) begin
                    check("ts_hold_valid", ts_axis.tvalid, 1);
                    check("ts_hold_data", ts_axis.tdata, t_prev);
                end
                if (m_axis.tvalid && m_axis.tlast) check("no_accept_flush", s_axis.tready, 0);
                if (ts_axis.tvalid) check("no_accept_ts", s_axis.tready, 0);
                if (m_axis.tvalid && m_axis.tready) begin
                    frame_beats++;
                    last_data  = m_axis.tdata;
                    last_tlast = m_axis.tlast;
                    if (exp_frame.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL frame_extra: got beat %0h, required none", m_axis.tdata);
                    end else begin
                        e = exp_frame.pop_front();
                        check("frame_beat", {m_axis.tlast, m_axis.tdata}, e);
                    end
                end
                if (ts_axis.tvalid && ts_axis.tready) begin
                    ts_beats++;
                    last_ts = ts_axis.tdata;
                    if (exp_ts.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL ts_extra: got %0h, required none", ts_axis.tdata);
                    end else begin
                        check("ts_value", ts_axis.tdata, exp_ts.pop_front());
                    end
                end
                if (err_runt) begin
                    runt_seen++;
                    n_cmp++;
                    if (runt_pending == 0) begin
                        n_fail++;
                        $display("FAIL runt_extra: got err_runt=1, required 0");
                    end else begin
                        runt_pending--;
                    end
                end
                m_stall = m_axis.tvalid && !m_axis.tready;
                m_prev  = {m_axis.tlast, m_axis.tdata};
                t_stall = ts_axis.tvalid && !ts_axis.tready;
                t_prev  = ts_axis.tdata;
            end
        end
    end

    // Ready generator
    logic rand_rdy  = 1'b0;
    logic m_rdy_fix = 1'b1;
    logic t_rdy_fix = 1'b1;
    initial begin
        m_axis.tready  = 1'b1;
        ts_axis.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                m_axis.tready  = 1'($urandom_range(1, 0));
                ts_axis.tready = 1'($urandom_range(1, 0));
            end else begin
                m_axis.tready  = m_rdy_fix;
                ts_axis.tready = t_rdy_fix;
            end
        end
    end

    // Drives a packet; stop_at >= 0 abandons it after that many accepted beats.
    // Called just after a rising edge.
    task automatic send(input byte_q_t p, input int gap_pct, input int stop_at);
        logic acc;
        int   to;
        model_push(p);
        for (int i = 0; i < p.size(); i++) begin
            if (stop_at >= 0 && i >= stop_at) break;
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                s_axis.tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = p[i];
            s_axis.tlast  = (i == p.size() - 1);
            acc = 1'b0;
            to  = 0;
            while (!acc) begin
                @(negedge clk);
                acc = s_axis.tready;
                @(posedge clk);
                #1;
                if (!acc) begin
                    to++;
                    if (to > 5000) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL accept_timeout: beat %0d not accepted, required accept", i);
                        s_axis.tvalid = 1'b0;
                        return;
                    end
                end
            end
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    // Waits until the model has nothing outstanding, then realigns just after a rising edge.
    task automatic drain();
        int to;
        to = 0;
        while ((exp_frame.size() != 0 || exp_ts.size() != 0 || runt_pending != 0) && to < 5000) begin
            @(negedge clk);
            to++;
        end
        if (to >= 5000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d frame beats outstanding, required 0", exp_frame.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic byte_q_t make_pkt(input int flen, input logic [DW-1:0] base,
                                         input logic [TSW-1:0] ts);
        byte_q_t p;
        for (int i = 0; i < flen; i++) p.push_back(base + DW'(i));
        for (int j = 0; j < int'(N); j++) p.push_back(ts[j*DW +: DW]);
        return p;
    endfunction

    initial begin
        byte_q_t p1, p2;
        int      fb0, tb0, r0, to;

        rstn          = 1'b0;
        s_axis.tvalid = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("rst_m_tvalid", m_axis.tvalid, 0);
        check("rst_ts_tvalid", ts_axis.tvalid, 0);
        check("rst_s_tready", s_axis.tready, 1);
        check("rst_err_runt", err_runt, 0);
        @(posedge clk);
        #1;

        // 64-byte frame 00..3F, timestamp beats 09..01
        fb0 = frame_beats; tb0 = ts_beats; r0 = runt_seen;
        send(make_pkt(64, 8'h00, 72'h010203040506070809), 0, -1);
        drain();
        check("t1_beats", frame_beats - fb0, 64);
        check("t1_last_data", last_data, 8'h3F);
        check("t1_last_tlast", last_tlast, 1);
        check("t1_ts", last_ts, 72'h010203040506070809);
        check("t1_ts_beats", ts_beats - tb0, 1);
        check("t1_no_runt", runt_seen - r0, 0);

        // Minimum frame: single byte AA
        fb0 = frame_beats; tb0 = ts_beats;
        send(make_pkt(1, 8'hAA, 72'h998877665544332211), 0, -1);
        drain();
        check("t2_beats", frame_beats - fb0, 1);
        check("t2_data", last_data, 8'hAA);
        check("t2_tlast", last_tlast, 1);
        check("t2_ts", last_ts, 72'h998877665544332211);

        // Runt of N beats, then a normal packet
        fb0 = frame_beats; tb0 = ts_beats; r0 = runt_seen;
        send(make_pkt(0, 8'h00, 72'h090807060504030201), 0, -1);
        drain();
        check("t3_runt_pulses", runt_seen - r0, 1);
        check("t3_runt_no_frame", frame_beats - fb0, 0);
        check("t3_runt_no_ts", ts_beats - tb0, 0);
        fb0 = frame_beats; tb0 = ts_beats;
        send(make_pkt(64, 8'h40, 72'hF0E0D0C0B0A0908070), 0, -1);
        drain();
        check("t3_after_beats", frame_beats - fb0, 64);
        check("t3_after_ts", last_ts, 72'hF0E0D0C0B0A0908070);

        // Reset in the middle of streaming
        send(make_pkt(64, 8'h10, 72'h0), 0, 30);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("mid_rst_m_tvalid", m_axis.tvalid, 0);
        check("mid_rst_ts_tvalid", ts_axis.tvalid, 0);
        check("mid_rst_s_tready", s_axis.tready, 1);
        @(posedge clk);
        #1;
        fb0 = frame_beats;
        send(make_pkt(64, 8'h80, 72'h0), 0, -1);
        drain();
        check("t4_beats", frame_beats - fb0, 64);
        check("t4_zero_ts", last_ts, 72'h0);

        // Back-to-back packets with the timestamp held off for 20 cycles
        p1 = make_pkt(5, 8'h20, 72'h123456789ABCDEF012);
        p2 = make_pkt(3, 8'h60, 72'h0F1E2D3C4B5A697887);
        t_rdy_fix = 1'b0;
        fork
            begin
                send(p1, 0, -1);
                send(p2, 0, -1);
            end
            begin
                to = 0;
                @(negedge clk);
                while (!ts_axis.tvalid && to < 500) begin
                    @(negedge clk);
                    to++;
                end
                check("t5_ts_seen", ts_axis.tvalid, 1);
                for (int k = 0; k < 20; k++) begin
                    check("t5_hold_s_tready", s_axis.tready, 0);
                    @(negedge clk);
                end
                t_rdy_fix = 1'b1;
                @(negedge clk);
                check("t5_release_hs", ts_axis.tvalid & ts_axis.tready, 1);
                @(negedge clk);
                check("t5_fill_s_tready", s_axis.tready, 1);
                check("t5_fill_ts_tvalid", ts_axis.tvalid, 0);
            end
        join
        drain();

        // Random readies and input gaps
        rand_rdy = 1'b1;
        for (int n = 0; n < 100; n++) begin
            byte_q_t p;
            int      len;
            len = (n == 0) ? 1500 + int'(N) : int'($urandom_range(200, 1));
            for (int i = 0; i < len; i++) p.push_back(DW'($urandom));
            send(p, 30, -1);
        end
        drain();
        rand_rdy = 1'b0;
        drain();

        check("end_frame_q", exp_frame.size(), 0);
        check("end_ts_q", exp_ts.size(), 0);
        check("end_runt_pending", runt_pending, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
